// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and latency classes for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADD  = 4'd7;
  localparam logic [3:0] MADDU = 4'd8;
  localparam logic [3:0] MSUB  = 4'd9;
  localparam logic [3:0] MSUBU = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    LAT_NONE = 2'd0,  // zero-latency or no-op
    LAT_MUL  = 2'd1,
    LAT_DIV  = 2'd2
  } lat_e;

  // Which busy-cycle budget an op code needs; LAT_NONE for moves and undefined codes.
  function automatic lat_e lat_class(input logic [3:0] op);
    case (op)
      MULT, MULTU, MADD, MADDU, MSUB, MSUBU: return LAT_MUL;
      DIV, DIVU:                             return LAT_DIV;
      default:                               return LAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational arithmetic: produces the {hi,lo} result of one long op.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   r;

  assign acc = {hi, lo};

  // Multiplying sign-extended operands gives the signed product in the low 2*WIDTH bits.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // One unsigned divider serves both div and divu; signed div works on magnitudes
  // and fixes signs afterwards (quotient toward zero, remainder follows dividend).
  assign sgn   = (op == DIV);
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign dvd   = a_neg ? -a : a;
  assign dvs   = b_neg ? -b : b;
  assign uq    = dvd / dvs;
  assign ur    = dvd % dvs;
  assign q     = (a_neg ^ b_neg) ? -uq : uq;
  assign r     = a_neg ? -ur : ur;

  // Select the result for the requested op, applying the div-by-zero and overflow rules.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
    result = acc;
    case (op)
      MULT:  result = prod_s;
      MULTU: result = prod_u;
      MADD:  result = acc + prod_s;
      MADDU: result = acc + prod_u;
      MSUB:  result = acc - prod_s;
      MSUBU: result = acc - prod_u;
      DIV, DIVU: begin
        if (b == '0)
          result = {a, {WIDTH{1'b1}}};
        else if (sgn && (a == MOST_NEG) && (b == '1))
          result = {{WIDTH{1'b0}}, MOST_NEG};
        else
          result = {r, q};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit_p.sv
// Sequencing wrapper: IDLE/RUN FSM, latency counter, pending result and HI/LO registers.
module muldiv_unit_p
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pending;
  logic [2*WIDTH-1:0] core_res;
  logic               accept;
  logic               commit;
  logic               wr_hi;
  logic               wr_lo;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .result (core_res)
  );

  assign busy = (state_q == RUN);

  // Next-state, counter and register-write decisions; flush wins over start and commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (lat_class(op))
            LAT_MUL: begin
              accept  = 1'b1;
              state_d = RUN;
              cnt_d   = CW'(MUL_CYCLES - 1);
            end
            LAT_DIV: begin
              accept  = 1'b1;
              state_d = RUN;
              cnt_d   = CW'(DIV_CYCLES - 1);
            end
            default: begin
              wr_hi = (op == MTHI);
              wr_lo = (op == MTLO);
            end
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending result capture, commit into HI/LO, and mthi/mtlo moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: pending is reset too, so a reset mid-op can never leak a stale result later.
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (accept) pending <= core_res;
      if (commit) {hi, lo} <= pending;
      if (wr_hi)  hi <= a;
      if (wr_lo)  lo <= a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit_p.sv
// Directed self-checking bench for muldiv_unit_p with hand-computed expectations.
module tb_muldiv_unit_p;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit_p #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues a long op, checks busy for n cycles, then the result.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int n,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      check({tag, " busy"}, 64'(busy), 64'(1));
      if (c < n) @(negedge clk);
    end
    @(negedge clk);
    check({tag, " idle"}, 64'(busy), 64'(0));
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
  endtask

  // One-cycle start of a zero-latency op; returns at the following negedge.
  task automatic pulse(input logic [3:0] o, input logic [W-1:0] x);
    start = 1'b1; op = o; a = x; b = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = NONE; a = '0; b = '0;
    #12;
    check("reset busy", 64'(busy), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Multiply and divide, issued back-to-back.
    run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", DIVU, 32'd7, 32'd0, DC, 32'd7, 32'hFFFF_FFFF);
    run_op("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);

    // Moves and accumulate.
    pulse(MTHI, 32'd0);
    check("mthi hi", 64'(hi), 64'(0));
    check("mthi busy", 64'(busy), 64'(0));
    pulse(MTLO, 32'hFFFF_FFFF);
    check("mtlo lo", 64'(lo), 64'hFFFF_FFFF);
    check("mtlo busy", 64'(busy), 64'(0));
    run_op("maddu", MADDU, 32'd1, 32'd1, MC, 32'd1, 32'd0);
    run_op("msub", MSUB, 32'd1, 32'd1, MC, 32'd0, 32'hFFFF_FFFF);
    run_op("madd", MADD, 32'hFFFF_FFFF, 32'd2, MC, 32'd0, 32'hFFFF_FFFD);

    // Undefined op code is a no-op.
    pulse(4'd12, 32'd123);
    check("undef busy", 64'(busy), 64'(0));
    check("undef hi", 64'(hi), 64'(0));
    check("undef lo", 64'(lo), 64'hFFFF_FFFD);

    // Flush in the final busy cycle aborts without commit.
    pulse(MTHI, 32'h11);
    pulse(MTLO, 32'h22);
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < MC; c++) begin
      check("flush pre busy", 64'(busy), 64'(1));
      @(negedge clk);
    end
    check("flush last busy", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'(0));
    check("flush hi", 64'(hi), 64'h11);
    check("flush lo", 64'(lo), 64'h22);
    repeat (MC) @(negedge clk);
    check("flush late hi", 64'(hi), 64'h11);
    check("flush late lo", 64'(lo), 64'h22);

    // Flush blocks a same-cycle move and a same-cycle long op.
    flush = 1'b1; start = 1'b1; op = MTLO; a = 32'h99;
    @(negedge clk);
    check("flush mtlo lo", 64'(lo), 64'h22);
    op = MULT; a = 32'd2; b = 32'd2;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush start busy", 64'(busy), 64'(0));

    // Starts while busy are ignored.
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= DC; c++) begin
      check("ign busy", 64'(busy), 64'(1));
      if (c == 3) begin start = 1'b1; op = MTLO; a = 32'h55; end
      if (c == 5) begin start = 1'b1; op = MULT; a = 32'd5; b = 32'd5; end
      @(negedge clk);
      start = 1'b0;
    end
    check("ign idle", 64'(busy), 64'(0));
    check("ign hi", 64'(hi), 64'd2);
    check("ign lo", 64'(lo), 64'd14);

    // Asynchronous reset mid-op.
    start = 1'b1; op = MULT; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst hi", 64'(hi), 64'(0));
    check("rst lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (MC + 1) @(negedge clk);
    check("rst after busy", 64'(busy), 64'(0));
    check("rst after lo", 64'(lo), 64'(0));
    run_op("multu", MULTU, 32'd2, 32'd2, MC, 32'd0, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
